hilo_mdu: RTL and testbench



---
 rtl/hilo_mdu_pkg.sv | 38 +++
 rtl/mdu_step.sv | 37 +++
 rtl/hilo_mdu.sv | 142 ++++++++++++++
 tb/tb_hilo_mdu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_mdu_pkg.sv
// ============================================================================
// Module  : hilo_mdu_pkg
// Brief   : Shared operation codes, FSM states and helpers for the HI/LO MDU.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hilo_mdu_pkg;

  localparam int MDU_DATA_W = 32;

  typedef enum logic [2:0] {
    MDU_OP_MULT  = 3'd0,
    MDU_OP_MULTU = 3'd1,
    MDU_OP_DIV   = 3'd2,
    MDU_OP_DIVU  = 3'd3,
    MDU_OP_MTHI  = 3'd4,
    MDU_OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic [MDU_DATA_W-1:0] neg_w(input logic [MDU_DATA_W-1:0] v);
    return ~v + MDU_DATA_W'(1);
  endfunction

  function automatic logic [MDU_DATA_W-1:0] mag_w(input logic [MDU_DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[MDU_DATA_W-1]) ? neg_w(v) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// Module  : mdu_step
// Brief   : One radix-2 iteration: shift-add multiply or restoring divide.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_step
  import hilo_mdu_pkg::*;
#(
  parameter int W = MDU_DATA_W
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  logic           is_div,
  output logic [2*W-1:0] acc_next
);

  logic [W:0] w_mul_sum;
  logic [W:0] w_rem_sh;
  logic [W:0] w_diff;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
  always_comb begin
    w_mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    w_rem_sh  = acc[2*W-1:W-1];
    w_diff    = w_rem_sh - {1'b0, operand};
    acc_next  = {w_mul_sum, acc[W-1:1]};
    if (is_div) begin
      if (!w_diff[W]) acc_next = {w_diff[W-1:0], acc[W-2:0], 1'b1};
      else            acc_next = {w_rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/hilo_mdu.sv
// ============================================================================
// Module  : hilo_mdu
// Brief   : Iterative MULT/DIV unit driving the HI/LO register file writes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITERS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  output logic              busy,
  output logic              we_hi,
  output logic              we_lo,
  output logic [DATA_W-1:0] wd_hi,
  output logic [DATA_W-1:0] wd_lo
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(ITERS - 1);

  mdu_state_e          r_state;
  mdu_state_e          w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_opnd;
  logic                r_is_div;
  logic                r_neg_lo;
  logic                r_neg_hi;

  logic [2*DATA_W-1:0] w_acc_next;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_res_hi;
  logic [DATA_W-1:0]   w_res_lo;
  logic                w_accept;
  logic                w_is_mt;
  logic                w_is_div;
  logic                w_signed;
  logic                w_last;

  mdu_step #(.W(DATA_W)) u_step (
    .acc      (r_acc),
    .operand  (r_opnd),
    .is_div   (r_is_div),
    .acc_next (w_acc_next)
  );

  always_comb begin
    w_is_mt  = (op == MDU_OP_MTHI) || (op == MDU_OP_MTLO);
    w_is_div = (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    w_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    w_last   = (r_state == ST_CALC) && (r_cnt == c_last);
    // Reserved ops (6, 7) are never accepted.
    w_accept = (r_state != ST_CALC) && start && (op < 3'd6);

    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_next_state = ST_IDLE;
        if (w_accept) w_next_state = w_is_mt ? ST_DONE : ST_CALC;
      end
      ST_CALC: if (w_last) w_next_state = ST_DONE;
      default: w_next_state = ST_IDLE;
    endcase
    if (flush) w_next_state = ST_IDLE;
  end

  // Sign fix-up is applied to the final step's output so the write data lands
  // in the same edge that enters DONE.
  always_comb begin
    w_prod   = r_neg_lo ? (~w_acc_next + (2*DATA_W)'(1)) : w_acc_next;
    w_res_lo = w_prod[DATA_W-1:0];
    w_res_hi = w_prod[2*DATA_W-1:DATA_W];
    if (r_is_div) begin
      w_res_lo = r_neg_lo ? neg_w(w_acc_next[DATA_W-1:0]) : w_acc_next[DATA_W-1:0];
      w_res_hi = r_neg_hi ? neg_w(w_acc_next[2*DATA_W-1:DATA_W])
                          : w_acc_next[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      busy     <= 1'b0;
      we_hi    <= 1'b0;
      we_lo    <= 1'b0;
      wd_hi    <= '0;
      wd_lo    <= '0;
    end else begin
      r_state <= w_next_state;
      busy    <= (w_next_state == ST_CALC);
      we_hi   <= 1'b0;
      we_lo   <= 1'b0;
      if (r_state == ST_CALC) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (!flush) begin
        if (w_accept && w_is_mt) begin
          if (op == MDU_OP_MTHI) begin
            we_hi <= 1'b1;
            wd_hi <= rs_val;
          end else begin
            we_lo <= 1'b1;
            wd_lo <= rs_val;
          end
        end else if (w_accept) begin
          r_cnt    <= '0;
          r_is_div <= w_is_div;
          r_neg_lo <= w_signed && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
          r_neg_hi <= w_signed && rs_val[DATA_W-1];
          r_acc    <= {{DATA_W{1'b0}}, mag_w(w_is_div ? rs_val : rt_val, w_signed)};
          r_opnd   <= mag_w(w_is_div ? rt_val : rs_val, w_signed);
        end
        if (w_last) begin
          we_hi <= 1'b1;
          we_lo <= 1'b1;
          wd_hi <= w_res_hi;
          wd_lo <= w_res_lo;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_mdu.sv
// ============================================================================
// Module  : tb_hilo_mdu
// Brief   : Directed and random stimulus against a transaction-level MDU model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_mdu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wd_hi;
  logic [31:0] wd_lo;

  hilo_mdu #(.DATA_W(32), .ITERS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .we_hi  (we_hi),
    .we_lo  (we_lo),
    .wd_hi  (wd_hi),
    .wd_lo  (wd_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %08h expected %08h", tag, $time, got, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ma;
    logic [63:0] mb;
    logic [63:0] q;
    logic [63:0] r;
    logic        sg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 3'd0) return 64'(sa * sb);
    if (o == 3'd1) return {32'h0, a} * {32'h0, b};
    sg = (o == 3'd2);
    ma = sg ? 64'((sa < 0) ? -sa : sa) : {32'h0, a};
    mb = sg ? 64'((sb < 0) ? -sb : sb) : {32'h0, b};
    if (mb == 64'd0) begin
      q = 64'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sg && ((sa < 0) != (sb < 0))) q = -q;
    if (sg && (sa < 0)) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction model: remaining latency of the op in flight plus expected outputs.
  bit          m_valid = 1'b0;
  int          m_rem   = 0;
  bit          m_free;
  logic [63:0] m_res;
  logic        e_busy, e_we_hi, e_we_lo;
  logic [31:0] e_wd_hi, e_wd_lo;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_rem   = 0;
      e_busy  = 1'b0;
      e_we_hi = 1'b0;
      e_we_lo = 1'b0;
      e_wd_hi = 32'h0;
      e_wd_lo = 32'h0;
    end else if (m_valid) begin
      e_we_hi = 1'b0;
      e_we_lo = 1'b0;
      if (flush) begin
        m_rem = 0;
      end else begin
        m_free = (m_rem == 0);
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            e_we_hi = 1'b1;
            e_we_lo = 1'b1;
            e_wd_hi = m_res[63:32];
            e_wd_lo = m_res[31:0];
          end
        end
        if (m_free && start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              m_res = ref_calc(op, rs_val, rt_val);
              m_rem = 32;
            end
            3'd4: begin
              e_we_hi = 1'b1;
              e_wd_hi = rs_val;
            end
            3'd5: begin
              e_we_lo = 1'b1;
              e_wd_lo = rs_val;
            end
            default: ;
          endcase
        end
      end
      e_busy = (m_rem > 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_eq("busy",  {31'h0, busy},  {31'h0, e_busy});
      check_eq("we_hi", {31'h0, we_hi}, {31'h0, e_we_hi});
      check_eq("we_lo", {31'h0, we_lo}, {31'h0, e_we_lo});
      check_eq("wd_hi", wd_hi, e_wd_hi);
      check_eq("wd_lo", wd_lo, e_wd_lo);
    end
  end

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic f, input logic r);
    @(negedge clk);
    start  = s;
    op     = o;
    rs_val = a;
    rt_val = b;
    flush  = f;
    rst    = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, o, a, b, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1 + ($urandom % 9);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'h0; rt_val = 32'h0; flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(2);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(34);
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);         idle(34);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);         idle(34);
    issue(3'd3, 32'd100, 32'd0);               idle(34);
    issue(3'd2, 32'hFFFF_FFFB, 32'd0);         idle(34);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); idle(34);

    // MTHI then MTLO back-to-back
    issue(3'd4, 32'h1234_5678, 32'h0);
    issue(3'd5, 32'hCAFE_F00D, 32'h0);
    idle(3);

    // DIVU flushed at T+10, then MULTU at T+11
    issue(3'd3, 32'd1000, 32'd7); idle(9);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    issue(3'd1, 32'h0001_0003, 32'h0002_0005); idle(36);

    // Second DIV during CALC is ignored
    issue(3'd2, 32'd12345, 32'hFFFF_FFF0); idle(4);
    issue(3'd2, 32'd99, 32'd3);            idle(36);

    // rst at T+20 mid-operation
    issue(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF); idle(19);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(3);

    // Back-to-back issue in DONE, flush together with start, reserved op
    issue(3'd0, 32'hFFFF_FFFF, 32'h8000_0000); idle(32);
    issue(3'd3, 32'hDEAD_BEEF, 32'd16);        idle(34);
    drive(1'b1, 3'd1, 32'd3, 32'd3, 1'b1, 1'b0); idle(2);
    issue(3'd6, 32'h5555_5555, 32'h1);         idle(2);
    issue(3'd7, 32'h5555_5555, 32'h1);         idle(2);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) == 0, 3'($urandom % 8), pick(), pick(),
            ($urandom % 60) == 0, ($urandom % 500) == 0);
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
